// File: rtl/packet_filter_pkg.sv
// packet_filter_pkg: shared buffer word, FSM states and default sizes for the packet filter
package packet_filter_pkg;
  localparam int PF_AST_DWIDTH = 64;
  localparam int PF_EMPTY_WIDTH = $clog2(PF_AST_DWIDTH / 8);
  localparam int PF_CHANNEL_WIDTH = 1;
  localparam int PF_BUF_DEPTH = 256;
  typedef struct packed {
    logic [PF_AST_DWIDTH-1:0] data;
    logic sop;
    logic eop;
    logic [PF_EMPTY_WIDTH-1:0] empty;
    logic [PF_CHANNEL_WIDTH-1:0] channel;
  } buf_word_t;
  typedef enum logic [1:0] {IDLE, STORE, DROP} state_e;
  function automatic logic [31:0] sat_add(input logic [31:0] a, input logic [1:0] n);
    logic [32:0] s;
    s = {1'b0, a} + {31'd0, n};
    return s[32] ? 32'hFFFF_FFFF : s[31:0];
  endfunction
endpackage

// File: rtl/packet_buffer_ram.sv
// packet_buffer_ram: simple dual-port packet store, one write port and one registered read port
module packet_buffer_ram
  import packet_filter_pkg::*;
#(
  parameter int DEPTH = PF_BUF_DEPTH,
  parameter int WIDTH = $bits(buf_word_t),
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk_i,
  input  logic             arst_n_i,
  input  logic             we_i,
  input  logic [AW-1:0]    waddr_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             re_i,
  input  logic [AW-1:0]    raddr_i,
  output logic [WIDTH-1:0] rdata_o
);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [WIDTH-1:0] rdata_q;
  always_ff @(posedge clk_i)
    if (we_i) mem[waddr_i] <= wdata_i;
  // the read register doubles as the output slot, so it must clear on reset
  always_ff @(posedge clk_i or negedge arst_n_i)
    if (!arst_n_i) rdata_q <= '0;
    else if (re_i) rdata_q <= mem[raddr_i];
  assign rdata_o = rdata_q;
endmodule

// File: rtl/packet_filter.sv
// packet_filter: buffers whole packets and forwards only those whose eop beat has a non-zero channel
// PACKET_FILTER_STATS_EN adds saturating pass/drop packet counters.
module packet_filter
  import packet_filter_pkg::*;
#(
  parameter int AST_DWIDTH = PF_AST_DWIDTH,
  parameter int CHANNEL_WIDTH = PF_CHANNEL_WIDTH,
  parameter int BUF_DEPTH = PF_BUF_DEPTH,
  localparam int EMPTY_WIDTH = $clog2(AST_DWIDTH / 8),
  localparam int ADDR_W = $clog2(BUF_DEPTH)
) (
  input  logic                     clk_i,
  input  logic                     arst_n_i,
  input  logic [AST_DWIDTH-1:0]    ast_sink_data_i,
  input  logic                     ast_sink_valid_i,
  output logic                     ast_sink_ready_o,
  input  logic                     ast_sink_startofpacket_i,
  input  logic                     ast_sink_endofpacket_i,
  input  logic [EMPTY_WIDTH-1:0]   ast_sink_empty_i,
  input  logic [CHANNEL_WIDTH-1:0] ast_sink_channel_i,
  output logic [AST_DWIDTH-1:0]    ast_src_data_o,
  output logic                     ast_src_valid_o,
  input  logic                     ast_src_ready_i,
  output logic                     ast_src_startofpacket_o,
  output logic                     ast_src_endofpacket_o,
  output logic [EMPTY_WIDTH-1:0]   ast_src_empty_o,
  output logic [CHANNEL_WIDTH-1:0] ast_src_channel_o
`ifdef PACKET_FILTER_STATS_EN
  ,
  output logic [31:0]              pass_cnt_o,
  output logic [31:0]              drop_cnt_o
`endif
);
  localparam int PW = ADDR_W + 1;
  localparam logic [PW-1:0] FULL_DIFF = PW'(BUF_DEPTH);
  state_e state_q;
  logic [PW-1:0] wr_ptr_q, commit_ptr_q, rd_ptr_q, rd_ptr_d, wa, wa_d;
  logic valid_q, full, acc, wr_en, match, rd_en, oversize, trunc, pass_ev, drop_ev;
  buf_word_t wr_word, rd_word;
  assign full = (wr_ptr_q - rd_ptr_q) == FULL_DIFF;
  assign ast_sink_ready_o = arst_n_i & ((state_q == DROP) | !full);
  assign acc = ast_sink_valid_i & ast_sink_ready_o;
  // a sop always restarts at the commit point, discarding any unfinished packet
  assign wa = ast_sink_startofpacket_i ? commit_ptr_q : wr_ptr_q;
  assign wa_d = wa + PW'(1);
  assign wr_en = acc & (ast_sink_startofpacket_i | (state_q == STORE));
  assign match = |ast_sink_channel_i;
  assign oversize = wr_en & !ast_sink_endofpacket_i & ((wa_d - commit_ptr_q) == FULL_DIFF);
  assign trunc = acc & ast_sink_startofpacket_i & (state_q == STORE);
  assign pass_ev = wr_en & ast_sink_endofpacket_i & match;
  assign drop_ev = wr_en & ast_sink_endofpacket_i & !match;
  assign rd_en = (rd_ptr_q != commit_ptr_q) & (!valid_q | ast_src_ready_i);
  assign rd_ptr_d = rd_ptr_q + PW'(1);
  assign wr_word = {ast_sink_data_i, ast_sink_startofpacket_i, ast_sink_endofpacket_i,
                    ast_sink_empty_i, ast_sink_channel_i};
  always_ff @(posedge clk_i or negedge arst_n_i)
    if (!arst_n_i) begin
      state_q <= IDLE;
      wr_ptr_q <= '0;
      commit_ptr_q <= '0;
      rd_ptr_q <= '0;
      valid_q <= 1'b0;
    end else begin
      if (wr_en) begin
        if (ast_sink_endofpacket_i) begin
          state_q <= IDLE;
          if (match) begin
            commit_ptr_q <= wa_d;
            wr_ptr_q <= wa_d;
          end else wr_ptr_q <= commit_ptr_q;
        end else if (oversize) begin
          state_q <= DROP;
          wr_ptr_q <= commit_ptr_q;
        end else begin
          state_q <= STORE;
          wr_ptr_q <= wa_d;
        end
      end else if (acc & ast_sink_endofpacket_i & (state_q == DROP)) state_q <= IDLE;
      if (rd_en) rd_ptr_q <= rd_ptr_d;
      valid_q <= rd_en | (valid_q & !ast_src_ready_i);
    end
  packet_buffer_ram #(.DEPTH(BUF_DEPTH), .WIDTH($bits(buf_word_t))) u_ram (
    .clk_i   (clk_i),
    .arst_n_i(arst_n_i),
    .we_i    (wr_en),
    .waddr_i (wa[ADDR_W-1:0]),
    .wdata_i (wr_word),
    .re_i    (rd_en),
    .raddr_i (rd_ptr_q[ADDR_W-1:0]),
    .rdata_o (rd_word)
  );
  assign ast_src_valid_o = valid_q;
  assign ast_src_data_o = rd_word.data;
  assign ast_src_startofpacket_o = rd_word.sop;
  assign ast_src_endofpacket_o = rd_word.eop;
  assign ast_src_empty_o = rd_word.empty;
  assign ast_src_channel_o = rd_word.channel;
`ifdef PACKET_FILTER_STATS_EN
  logic [31:0] pass_cnt_q, drop_cnt_q;
  logic [1:0] drop_n;
  // a truncating sop can also end a non-matching single-beat packet: two drops at once
  assign drop_n = {1'b0, trunc} + {1'b0, drop_ev | oversize};
  always_ff @(posedge clk_i or negedge arst_n_i)
    if (!arst_n_i) begin
      pass_cnt_q <= '0;
      drop_cnt_q <= '0;
    end else begin
      pass_cnt_q <= sat_add(pass_cnt_q, {1'b0, pass_ev});
      drop_cnt_q <= sat_add(drop_cnt_q, drop_n);
    end
  assign pass_cnt_o = pass_cnt_q;
  assign drop_cnt_o = drop_cnt_q;
`else
  logic unused_stats;
  assign unused_stats = ^{trunc, pass_ev, drop_ev};
`endif
endmodule
